// File: rtl/mips32_prog_loader.sv
// Byte-stream program loader for mips32: parses framed images into 32-bit memory writes,
// holds the CPU halted while loading and releases it with a start PC once the checksum matches.
module mips32_prog_loader #(
    parameter int          ADDR_W = 10,
    parameter logic [7:0]  SYNC   = 8'hA5
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              cpu_start,
    output logic [ADDR_W-1:0] start_pc,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE, S_A_HI, S_A_LO, S_C_HI, S_C_LO, S_DATA, S_CHK, S_RUN
    } state_t;

    state_t              state_q;
    logic [7:0]          ahi_q;
    logic [7:0]          chi_q;
    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W-1:0]   waddr_q;
    logic [15:0]         cnt_q;
    logic [1:0]          bcnt_q;
    logic [31:0]         word_q;
    logic [7:0]          xor_q;

    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [31:0]         mem_wdata_q;
    logic                cpu_hold_q;
    logic                cpu_start_q;
    logic [ADDR_W-1:0]   start_pc_q;
    logic                err_q;

    logic [31:0]         word_d;
    logic [ADDR_W-1:0]   base_d;
    logic [15:0]         cnt_d;
    logic [7:0]          xor_d;

    assign word_d = {word_q[23:0], in_data};
    assign base_d = ADDR_W'({ahi_q, in_data});
    assign cnt_d  = {chi_q, in_data};
    assign xor_d  = xor_q ^ in_data;

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ahi_q       <= '0;
            chi_q       <= '0;
            base_q      <= '0;
            waddr_q     <= '0;
            cnt_q       <= '0;
            bcnt_q      <= '0;
            word_q      <= '0;
            xor_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_hold_q  <= 1'b1;
            cpu_start_q <= 1'b0;
            start_pc_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            mem_we_q    <= 1'b0;
            cpu_start_q <= 1'b0;
            if (in_valid) begin
                case (state_q)
                    S_IDLE: begin
                        if (in_data == SYNC) begin
                            state_q <= S_A_HI;
                            err_q   <= 1'b0;
                            xor_q   <= '0;
                        end
                    end
                    S_A_HI: begin
                        ahi_q   <= in_data;
                        xor_q   <= xor_d;
                        state_q <= S_A_LO;
                    end
                    S_A_LO: begin
                        base_q  <= base_d;
                        waddr_q <= base_d;
                        xor_q   <= xor_d;
                        state_q <= S_C_HI;
                    end
                    S_C_HI: begin
                        chi_q   <= in_data;
                        xor_q   <= xor_d;
                        state_q <= S_C_LO;
                    end
                    S_C_LO: begin
                        cnt_q   <= cnt_d;
                        bcnt_q  <= '0;
                        xor_q   <= xor_d;
                        state_q <= (cnt_d != 16'd0) ? S_DATA : S_CHK;
                    end
                    S_DATA: begin
                        word_q <= word_d;
                        xor_q  <= xor_d;
                        bcnt_q <= bcnt_q + 2'd1;
                        // Fourth byte completes the word: emit it and advance (address wraps naturally).
                        if (bcnt_q == 2'd3) begin
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= waddr_q;
                            mem_wdata_q <= word_d;
                            waddr_q     <= waddr_q + 1'b1;
                            cnt_q       <= cnt_q - 16'd1;
                            if (cnt_q == 16'd1) begin
                                state_q <= S_CHK;
                            end
                        end
                    end
                    S_CHK: begin
                        if (in_data == xor_q) begin
                            state_q     <= S_RUN;
                            start_pc_q  <= base_q;
                            cpu_hold_q  <= 1'b0;
                            cpu_start_q <= 1'b1;
                        end else begin
                            state_q <= S_IDLE;
                            err_q   <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        // A new SYNC halts the CPU again while it is reloaded.
                        if (in_data == SYNC) begin
                            state_q    <= S_A_HI;
                            cpu_hold_q <= 1'b1;
                            err_q      <= 1'b0;
                            xor_q      <= '0;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign in_ready  = 1'b1;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign cpu_start = cpu_start_q;
    assign start_pc  = start_pc_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Bench for mips32_prog_loader: frame-level model predicts writes, start pulses, hold and error
// state, and a per-cycle compare process checks every output against it.
module tb_mips32_prog_loader;

    localparam int ADDR_W = 10;

    logic              clk1 = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              cpu_start;
    logic [ADDR_W-1:0] start_pc;
    logic              err;

    mips32_prog_loader #(.ADDR_W(ADDR_W), .SYNC(8'hA5)) dut (
        .clk1(clk1), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
        .cpu_start(cpu_start), .start_pc(start_pc), .err(err)
    );

    always #5 clk1 = ~clk1;

    int errors = 0;
    int checks = 0;
    bit run_chk = 1'b0;

    // Expected outputs after the next rising edge, set by the driver together with each byte.
    logic              exp_we = 1'b0;
    logic [ADDR_W-1:0] exp_addr = '0;
    logic [31:0]       exp_data = '0;
    logic              exp_start = 1'b0;
    logic [ADDR_W-1:0] exp_pc = '0;
    logic              exp_hold = 1'b1;
    logic              exp_err = 1'b0;

    logic [31:0]       words [8];
    logic [ADDR_W+31:0] wlog [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk1);
            #1;
            if (run_chk) begin
                check("in_ready", 32'(in_ready), 32'd1);
                check("mem_we", 32'(mem_we), 32'(exp_we));
                if (exp_we) begin
                    check("mem_addr", 32'(mem_addr), 32'(exp_addr));
                    check("mem_wdata", mem_wdata, exp_data);
                end
                check("cpu_start", 32'(cpu_start), 32'(exp_start));
                check("start_pc", 32'(start_pc), 32'(exp_pc));
                check("cpu_hold", 32'(cpu_hold), 32'(exp_hold));
                check("err", 32'(err), 32'(exp_err));
                if (mem_we) wlog.push_back({mem_addr, mem_wdata});
            end
        end
    end

    function automatic logic [7:0] frame_chk(input logic [15:0] base, input int n);
        logic [7:0] x;
        x = base[15:8] ^ base[7:0] ^ 8'(n >> 8) ^ 8'(n);
        for (int i = 0; i < n; i++)
            x = x ^ words[i][31:24] ^ words[i][23:16] ^ words[i][15:8] ^ words[i][7:0];
        return x;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk1);
        in_valid  = 1'b1;
        in_data   = b;
        exp_we    = 1'b0;
        exp_start = 1'b0;
    endtask

    // Idle cycles present 0xA5 with in_valid low so an ungated loader would misbehave.
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk1);
            in_valid  = 1'b0;
            in_data   = 8'hA5;
            exp_we    = 1'b0;
            exp_start = 1'b0;
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
        check({tag, "_cpu_start"}, 32'(cpu_start), 32'd0);
        check({tag, "_start_pc"}, 32'(start_pc), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk1);
        rst       = 1'b1;
        in_valid  = 1'b0;
        exp_we    = 1'b0;
        exp_start = 1'b0;
        exp_hold  = 1'b1;
        exp_err   = 1'b0;
        exp_pc    = '0;
        #1;
        check_reset("midrst");
        repeat (2) @(negedge clk1);
        rst = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] base, input int n, input bit bad,
                              input int abort_at, input bit gappy);
        logic [7:0] chk;
        chk = frame_chk(base, n);
        if (bad) chk = 8'h00;
        send_byte(8'hA5);
        exp_hold = 1'b1;
        exp_err  = 1'b0;
        send_byte(base[15:8]);
        send_byte(base[7:0]);
        send_byte(8'(n >> 8));
        send_byte(8'(n));
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (abort_at == i * 4 + j) begin
                    do_reset();
                    return;
                end
                send_byte(words[i][31 - 8 * j -: 8]);
                if (j == 3) begin
                    exp_we   = 1'b1;
                    exp_addr = ADDR_W'(32'(base) + i);
                    exp_data = words[i];
                end
                if (gappy) idle(1);
            end
        end
        send_byte(chk);
        if (!bad && chk == frame_chk(base, n)) begin
            exp_start = 1'b1;
            exp_pc    = ADDR_W'(base);
            exp_hold  = 1'b0;
        end else begin
            exp_err = 1'b1;
        end
        idle(2);
    endtask

    initial begin
        run_chk = 1'b1;
        repeat (2) @(negedge clk1);
        check_reset("reset");
        rst = 1'b0;
        idle(2);

        // Hand-computed checksums pin the model.
        words[0] = 32'h280A00C8;
        words[1] = 32'h28020001;
        check("model_chk_frame1", 32'(frame_chk(16'h0000, 2)), 32'h0000_00C3);
        check("model_chk_count0", 32'(frame_chk(16'h0005, 0)), 32'h0000_0005);

        // Two-word frame at base 0, back-to-back bytes.
        wlog.delete();
        send_frame(16'h0000, 2, 1'b0, -1, 1'b0);
        check("f1_nwrites", 32'(wlog.size()), 32'd2);
        check("f1_w0", wlog[0][31:0], 32'h280A00C8);
        check("f1_a1", 32'(wlog[1][ADDR_W+31:32]), 32'd1);
        check("f1_w1", wlog[1][31:0], 32'h28020001);
        check("f1_hold", 32'(cpu_hold), 32'd0);

        // Non-SYNC bytes in RUN are ignored.
        send_byte(8'h00);
        send_byte(8'h5A);
        idle(2);

        // Bad checksum, junk in IDLE, then a good frame clears the error.
        send_frame(16'h0000, 2, 1'b1, -1, 1'b0);
        check("bad_err", 32'(err), 32'd1);
        check("bad_hold", 32'(cpu_hold), 32'd1);
        send_byte(8'h12);
        idle(1);
        send_frame(16'h0000, 2, 1'b0, -1, 1'b0);
        check("good_err", 32'(err), 32'd0);

        // Single word at base 200, with gaps between bytes.
        words[0] = 32'h00000007;
        check("model_chk_b200", 32'(frame_chk(16'h00C8, 1)), 32'h0000_00CE);
        wlog.delete();
        send_frame(16'h00C8, 1, 1'b0, -1, 1'b1);
        check("b200_pc", 32'(start_pc), 32'd200);
        check("b200_addr", 32'(wlog[0][ADDR_W+31:32]), 32'd200);

        // Address wrap 1023 -> 0.
        words[0] = 32'h11111111;
        words[1] = 32'h22222222;
        wlog.delete();
        send_frame(16'h03FF, 2, 1'b0, -1, 1'b0);
        check("wrap_a0", 32'(wlog[0][ADDR_W+31:32]), 32'd1023);
        check("wrap_a1", 32'(wlog[1][ADDR_W+31:32]), 32'd0);

        // Zero-count frame.
        wlog.delete();
        send_frame(16'h0005, 0, 1'b0, -1, 1'b0);
        check("cnt0_nwrites", 32'(wlog.size()), 32'd0);
        check("cnt0_pc", 32'(start_pc), 32'd5);

        // Upper base bits beyond ADDR_W are dropped.
        words[0] = 32'hDEADBEEF;
        send_frame(16'hFC01, 1, 1'b0, -1, 1'b0);
        check("trunc_pc", 32'(start_pc), 32'd1);

        // Reset after 6 data bytes, then resend the full frame.
        words[0] = 32'h280A00C8;
        words[1] = 32'h28020001;
        wlog.delete();
        send_frame(16'h0000, 2, 1'b0, 6, 1'b0);
        idle(2);
        send_frame(16'h0000, 2, 1'b0, -1, 1'b0);
        check("abort_nwrites", 32'(wlog.size()), 32'd3);
        check("abort_w1", wlog[1][31:0], 32'h280A00C8);
        check("abort_w2", wlog[2][31:0], 32'h28020001);

        // SYNC in RUN raises hold.
        send_byte(8'hA5);
        exp_hold = 1'b1;
        idle(2);
        check("resync_hold", 32'(cpu_hold), 32'd1);

        run_chk = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
